seg7_scan_display: RTL and testbench

//  Parametrised multi-digit hex display driver; successor to the single-digit 4-bit decoder.
//  - Captures a DATA_W-bit value on a load strobe into a shadow register.
//  - Drives NUM_DIGITS hex digits two ways:
//      - static: one 7-bit bus per digit (DE-board HEXn style);
//      - time-multiplexed: shared segment bus plus digit-select anodes.
//  - Adds optional leading-zero blanking and per-digit decimal points.
//  - Sits between the datapath result bus (register file / ALU output) and the board pins.

---
 rtl/seg7_pkg.sv | 18 +
 rtl/seg7_hex_decode.sv | 19 +
 rtl/seg7_scan_display.sv | 130 +++++++++++++
 tb/tb_seg7_scan_display.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants and hex-to-segment encoding for the seven-segment display drivers.
// Segment words are ordered {g,f,e,d,c,b,a}; the table is stored in active-low form.
package seg7_pkg;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   function automatic logic [6:0] seg7_encode(input logic [3:0] nibble, input logic act_low);
      return act_low ? SEG_TABLE[nibble] : ~SEG_TABLE[nibble];
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder with a blank override that forces the digit dark.
module seg7_hex_decode
   import seg7_pkg::*;
#(
   parameter bit ACT_LOW = 1'b1
) (
   input  logic [3:0] nibble_i,
   input  logic       blank_i,
   output logic [6:0] seg_o
);

   always_comb begin
      seg_o = ACT_LOW ? SEG_BLANK : ~SEG_BLANK;
      if (!blank_i) begin
         seg_o = seg7_encode(nibble_i, ACT_LOW);
      end
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Multi-digit hex display driver: shadow capture, static per-digit buses and a
// time-multiplexed scan bus with optional leading-zero blanking and decimal points.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS  = 8,
   parameter int DATA_W      = 32,
   parameter int REFRESH_DIV = 50000,
   parameter bit SEG_ACT_LOW = 1'b1,
   parameter bit AN_ACT_LOW  = 1'b1,
   localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [DATA_W-1:0]       data_in,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    blank_lz,
   input  logic                    enable,
   output logic [7*NUM_DIGITS-1:0] seg_static,
   output logic [6:0]              segments,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   anodes,
   output logic [IDX_W-1:0]        digit_idx
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam logic [6:0] SEG_OFF = SEG_ACT_LOW ? SEG_BLANK : ~SEG_BLANK;
   localparam logic DP_OFF = SEG_ACT_LOW;
   localparam logic [NUM_DIGITS-1:0] AN_OFF = AN_ACT_LOW ? '1 : '0;

   logic [DATA_W-1:0]              shadow_q;
   logic [NUM_DIGITS-1:0]          dpShadow_q;
   logic                           blank_q;
   logic [CNT_W-1:0]               divCnt_q, divCnt_d;
   logic [IDX_W-1:0]               digitIdx_q, digitIdx_d;
   logic [7*NUM_DIGITS-1:0]        segStatic_q, segStatic_d;
   logic [6:0]                     segments_q, segments_d;
   logic                           dp_q, dp_d;
   logic [NUM_DIGITS-1:0]          anodes_q, anodes_d;
   logic [NUM_DIGITS-1:0]          blankMask;
   logic [NUM_DIGITS-1:0][6:0]     digitSeg;
   logic [NUM_DIGITS-1:0]          selOneHot;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow_q   <= '0;
         dpShadow_q <= '0;
         blank_q    <= 1'b0;
      end else if (load) begin
         shadow_q   <= data_in;
         dpShadow_q <= dp_in;
         blank_q    <= blank_lz;
      end
   end

   // A digit is blanked when it and every digit above it are zero; digit 0 always shows.
   always_comb begin
      logic zeroAbove;
      zeroAbove = 1'b1;
      blankMask = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zeroAbove    = zeroAbove && (shadow_q[4*i +: 4] == 4'h0);
         blankMask[i] = blank_q && zeroAbove;
      end
   end

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      seg7_hex_decode #(
         .ACT_LOW (SEG_ACT_LOW)
      ) u_decode (
         .nibble_i (shadow_q[4*g +: 4]),
         .blank_i  (blankMask[g]),
         .seg_o    (digitSeg[g])
      );
   end

   always_comb begin
      divCnt_d   = divCnt_q;
      digitIdx_d = digitIdx_q;
      if (enable) begin
         if (divCnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            divCnt_d   = '0;
            digitIdx_d = (digitIdx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : digitIdx_q + IDX_W'(1);
         end else begin
            divCnt_d = divCnt_q + CNT_W'(1);
         end
      end
   end

   // Outputs are registered from the next digit index so anodes and segments switch together.
   always_comb begin
      segStatic_d = {NUM_DIGITS{SEG_OFF}};
      segments_d  = SEG_OFF;
      dp_d        = DP_OFF;
      anodes_d    = AN_OFF;
      selOneHot   = NUM_DIGITS'(1) << digitIdx_d;
      if (enable) begin
         segStatic_d = digitSeg;
         segments_d  = digitSeg[digitIdx_d];
         dp_d        = dpShadow_q[digitIdx_d] ? ~DP_OFF : DP_OFF;
         anodes_d    = AN_ACT_LOW ? ~selOneHot : selOneHot;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         divCnt_q    <= '0;
         digitIdx_q  <= '0;
         segStatic_q <= {NUM_DIGITS{SEG_OFF}};
         segments_q  <= SEG_OFF;
         dp_q        <= DP_OFF;
         anodes_q    <= AN_OFF;
      end else begin
         divCnt_q    <= divCnt_d;
         digitIdx_q  <= digitIdx_d;
         segStatic_q <= segStatic_d;
         segments_q  <= segments_d;
         dp_q        <= dp_d;
         anodes_q    <= anodes_d;
      end
   end

   assign seg_static = segStatic_q;
   assign segments   = segments_q;
   assign dp         = dp_q;
   assign anodes     = anodes_q;
   assign digit_idx  = digitIdx_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display (8 digits, 4-cycle refresh) using a
// tick-count reference model plus hand-computed literal expectations.
module tb_seg7_scan_display;

   localparam int ND   = 8;
   localparam int RDIV = 4;

   localparam logic [6:0] HEX_LUT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] data_in;
   logic        load;
   logic [7:0]  dp_in;
   logic        blank_lz;
   logic        enable;
   logic [55:0] seg_static;
   logic [6:0]  segments;
   logic        dp;
   logic [7:0]  anodes;
   logic [2:0]  digit_idx;

   int checks   = 0;
   int failures = 0;
   bit checking = 1'b0;

   logic [31:0] mShadow;
   logic [7:0]  mDp;
   logic        mBlank;
   int          mTicks;
   logic [55:0] mSegStatic;
   logic [6:0]  mSegs;
   logic        mDpOut;
   logic [7:0]  mAnodes;

   seg7_scan_display #(
      .NUM_DIGITS  (ND),
      .DATA_W      (32),
      .REFRESH_DIV (RDIV),
      .SEG_ACT_LOW (1'b1),
      .AN_ACT_LOW  (1'b1)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .data_in    (data_in),
      .load       (load),
      .dp_in      (dp_in),
      .blank_lz   (blank_lz),
      .enable     (enable),
      .seg_static (seg_static),
      .segments   (segments),
      .dp         (dp),
      .anodes     (anodes),
      .digit_idx  (digit_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] digitExp(input logic [31:0] v, input logic bl, input int i);
      logic [31:0] upper;
      upper = v >> (4 * i);
      if (bl && i > 0 && upper == 32'd0) return 7'h7F;
      return HEX_LUT[upper[3:0]];
   endfunction

   function automatic logic [55:0] staticExp(input logic [31:0] v, input logic bl);
      logic [55:0] s;
      s = '0;
      for (int i = 0; i < ND; i++) s[7*i +: 7] = digitExp(v, bl, i);
      return s;
   endfunction

   // Reference model: the scanned digit is simply (enabled edges / RDIV) mod ND.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mShadow    <= '0;
         mDp        <= '0;
         mBlank     <= 1'b0;
         mTicks     <= 0;
         mSegStatic <= '1;
         mSegs      <= 7'h7F;
         mDpOut     <= 1'b1;
         mAnodes    <= 8'hFF;
      end else begin
         if (load) begin
            mShadow <= data_in;
            mDp     <= dp_in;
            mBlank  <= blank_lz;
         end
         if (enable) begin
            mTicks     <= mTicks + 1;
            mSegStatic <= staticExp(mShadow, mBlank);
            mSegs      <= digitExp(mShadow, mBlank, ((mTicks + 1) / RDIV) % ND);
            mDpOut     <= ~mDp[((mTicks + 1) / RDIV) % ND];
            mAnodes    <= ~(8'b1 << (((mTicks + 1) / RDIV) % ND));
         end else begin
            mSegStatic <= '1;
            mSegs      <= 7'h7F;
            mDpOut     <= 1'b1;
            mAnodes    <= 8'hFF;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   always @(negedge clk) begin
      #1;
      if (checking) begin
         checkOutput("model_seg_static", 64'(seg_static), 64'(mSegStatic));
         checkOutput("model_segments", 64'(segments), 64'(mSegs));
         checkOutput("model_dp", 64'(dp), 64'(mDpOut));
         checkOutput("model_anodes", 64'(anodes), 64'(mAnodes));
         checkOutput("model_digit_idx", 64'(digit_idx), 64'((mTicks / RDIV) % ND));
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic applyStimulus(input logic ld, input logic [31:0] d, input logic [7:0] dpv,
                                input logic bl, input logic en);
      load     = ld;
      data_in  = d;
      dp_in    = dpv;
      blank_lz = bl;
      enable   = en;
      tick();
   endtask

   initial begin
      reset_n  = 1'b0;
      load     = 1'b0;
      data_in  = '0;
      dp_in    = '0;
      blank_lz = 1'b0;
      enable   = 1'b0;
      repeat (3) tick();
      reset_n  = 1'b1;
      checking = 1'b1;

      checkOutput("rst_seg_static", 64'(seg_static), 64'({56{1'b1}}));
      checkOutput("rst_segments", 64'(segments), 64'h7F);
      checkOutput("rst_anodes", 64'(anodes), 64'hFF);
      checkOutput("rst_dp", 64'(dp), 64'h1);
      checkOutput("rst_digit_idx", 64'(digit_idx), 64'h0);

      applyStimulus(1'b1, 32'h0000_00A5, 8'h00, 1'b0, 1'b1);
      checkOutput("load_edge_old_value", 64'(seg_static), 64'({8{7'b1000000}}));
      applyStimulus(1'b0, 32'h0000_00A5, 8'h00, 1'b0, 1'b1);
      checkOutput("static_A5_noblank", 64'(seg_static),
                  64'({{6{7'b1000000}}, 7'b0001000, 7'b0010010}));

      applyStimulus(1'b1, 32'h0000_00A5, 8'h00, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0000_00A5, 8'h00, 1'b1, 1'b1);
      checkOutput("static_A5_blank", 64'(seg_static),
                  64'({{6{7'h7F}}, 7'b0001000, 7'b0010010}));
      applyStimulus(1'b1, 32'h0000_0000, 8'h00, 1'b1, 1'b1);
      applyStimulus(1'b0, 32'h0000_0000, 8'h00, 1'b1, 1'b1);
      checkOutput("static_zero_blank", 64'(seg_static), 64'({{7{7'h7F}}, 7'b1000000}));

      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      applyStimulus(1'b1, 32'hFEDC_BA98, 8'h00, 1'b0, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         applyStimulus(1'b0, 32'hFEDC_BA98, 8'h00, 1'b0, 1'b1);
         if (k == 1) begin
            checkOutput("scan_first_anodes", 64'(anodes), 64'hFE);
            checkOutput("scan_first_segments", 64'(segments), 64'(7'b0000000));
         end
         if (k == 4) begin
            checkOutput("scan_wrap_anodes", 64'(anodes), 64'hFD);
            checkOutput("scan_wrap_idx", 64'(digit_idx), 64'h1);
            checkOutput("scan_wrap_segments", 64'(segments), 64'(7'b0010000));
         end
      end

      repeat (10) applyStimulus(1'b0, 32'hFEDC_BA98, 8'h00, 1'b0, 1'b0);
      checkOutput("disabled_segments", 64'(segments), 64'h7F);
      checkOutput("disabled_anodes", 64'(anodes), 64'hFF);
      checkOutput("disabled_static", 64'(seg_static), 64'({56{1'b1}}));
      checkOutput("disabled_idx_frozen", 64'(digit_idx), 64'h2);
      applyStimulus(1'b0, 32'hFEDC_BA98, 8'h00, 1'b0, 1'b1);
      checkOutput("reenable_anodes", 64'(anodes), 64'hFB);
      checkOutput("reenable_idx", 64'(digit_idx), 64'h2);
      checkOutput("reenable_segments", 64'(segments), 64'(7'b0001000));

      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_rst_segments", 64'(segments), 64'h7F);
      checkOutput("async_rst_anodes", 64'(anodes), 64'hFF);
      checkOutput("async_rst_idx", 64'(digit_idx), 64'h0);
      @(negedge clk);
      reset_n = 1'b1;

      repeat (3) applyStimulus(1'b0, 32'h0, 8'h00, 1'b0, 1'b1);
      applyStimulus(1'b1, 32'h1234_5678, 8'h01, 1'b0, 1'b1);
      checkOutput("wrap_load_old_segments", 64'(segments), 64'(7'b1000000));
      checkOutput("wrap_load_anodes", 64'(anodes), 64'hFD);
      checkOutput("wrap_load_dp", 64'(dp), 64'h1);
      applyStimulus(1'b0, 32'h1234_5678, 8'h01, 1'b0, 1'b1);
      checkOutput("wrap_load_new_segments", 64'(segments), 64'(7'b1111000));
      repeat (27) applyStimulus(1'b0, 32'h1234_5678, 8'h01, 1'b0, 1'b1);
      checkOutput("dp_digit0_anodes", 64'(anodes), 64'hFE);
      checkOutput("dp_digit0_lit", 64'(dp), 64'h0);
      checkOutput("dp_digit0_segments", 64'(segments), 64'(7'b0000000));
      repeat (4) applyStimulus(1'b0, 32'h1234_5678, 8'h01, 1'b0, 1'b1);
      checkOutput("dp_digit1_dark", 64'(dp), 64'h1);

      checking = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
